// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID pipeline definitions: word width, NOP encoding, default
// buffer depth and the packed {instr, pc_plus2} entry type.
package if_id_buffer_pkg;

    localparam int unsigned    XLEN            = 16;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF  = 16'h0800;
    localparam int unsigned    IF_ID_DEPTH_DEF = 2;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus2;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// master: fetch+decode side driving requests; slave: the buffer itself.
interface if_id_buffer_if;
    import if_id_buffer_pkg::*;

    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc_plus2;
    logic            if_valid;
    logic            if_ready;
    logic            id_stall;
    logic            flush;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc_plus2;
    logic            id_valid;

    modport master (
        output if_instr, if_pc_plus2, if_valid, id_stall, flush,
        input  if_ready, id_instr, id_pc_plus2, id_valid
    );

    modport slave (
        input  if_instr, if_pc_plus2, if_valid, id_stall, flush,
        output if_ready, id_instr, id_pc_plus2, id_valid
    );

endinterface

// File: rtl/if_id_buffer_storage.sv
// IF/ID entry storage: DEPTH x 32-bit register array, one write port,
// combinational read at the read pointer. Contents are not reset.
module if_id_storage
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IF_ID_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  if_id_entry_t             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output if_id_entry_t             rd_data
);

    if_id_entry_t mem_q [DEPTH];
    if_id_entry_t mem_d [DEPTH];

    // Next array contents: overwrite the addressed slot on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = wr_data;
        end
    end

    // Storage register array.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: small in-order queue between fetch and decode with
// valid/ready backpressure and flush on redirect. Presents NOP_INSTR with
// id_valid=0 when empty. Outputs depend on registered state only.
// Optional macro IF_ID_BUFFER_PERF_EN adds saturating stall_cnt/flush_cnt.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned     DEPTH     = IF_ID_DEPTH_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    if_id_buffer_if.slave      bus
`ifdef IF_ID_BUFFER_PERF_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic         if_ready_w;
    logic         id_valid_w;
    logic         push;
    logic         pop;
    if_id_entry_t wr_entry;
    if_id_entry_t rd_entry;

    assign if_ready_w = (count_q < DEPTH_C);
    assign id_valid_w = (count_q != '0);
    assign push       = bus.if_valid & if_ready_w & ~bus.flush;
    assign pop        = id_valid_w & ~bus.id_stall & ~bus.flush;

    assign wr_entry.instr    = bus.if_instr;
    assign wr_entry.pc_plus2 = bus.if_pc_plus2;

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr_q),
        .rd_data (rd_entry)
    );

    // Decode-facing outputs: head entry, or NOP/zero when empty.
    always_comb begin
        bus.if_ready    = if_ready_w;
        bus.id_valid    = id_valid_w;
        bus.id_instr    = NOP_INSTR;
        bus.id_pc_plus2 = '0;
        if (id_valid_w) begin
            bus.id_instr    = rd_entry.instr;
            bus.id_pc_plus2 = rd_entry.pc_plus2;
        end
    end

`ifdef IF_ID_BUFFER_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters: decode stalls on a valid head, and
    // flushes that actually throw away a held or offered entry.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_valid_w && bus.id_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (bus.flush && (id_valid_w || bus.if_valid) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: the stimulus side keeps a queue model of
// buffer contents and pushes per-cycle expectations; a monitor compares them.
`timescale 1ns/1ps
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    if_id_buffer_if bus ();

`ifdef IF_ID_BUFFER_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    if_id_buffer #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_ID_BUFFER_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        r;
        logic        st;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
    } cyc_t;

    if_id_entry_t expq [$];
    cyc_t         cycq [$];
    int           occ = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int unsigned  stall_mdl = 0;
    int unsigned  flush_mdl = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One fetch/decode cycle: drive inputs, advance the queue model.
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic st, input logic fl, output logic acc);
        cyc_t c;
        logic pp;
        @(negedge clk);
        bus.if_valid    = v;
        bus.if_instr    = ins;
        bus.if_pc_plus2 = pc;
        bus.id_stall    = st;
        bus.flush       = fl;
        c.v  = (occ > 0);
        c.r  = (occ < DEPTH);
        c.st = st;
        c.fl = fl;
        c.sc = 16'(stall_mdl);
        c.fc = 16'(flush_mdl);
        cycq.push_back(c);
        acc = v && c.r && !fl;
        pp  = c.v && !st && !fl;
        if (c.v && st && stall_mdl < 32'd65535) stall_mdl++;
        if (fl && (c.v || v) && flush_mdl < 32'd65535) flush_mdl++;
        if (fl) begin
            expq.delete();
            occ = 0;
        end else begin
            if (acc) expq.push_back('{instr: ins, pc_plus2: pc});
            occ = occ + int'(acc) - int'(pp);
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, "_id_instr"}, 32'(bus.id_instr), 32'h0800);
        chk({tag, "_id_pc"}, 32'(bus.id_pc_plus2), 32'd0);
        chk({tag, "_if_ready"}, 32'(bus.if_ready), 32'd1);
`ifdef IF_ID_BUFFER_PERF_EN
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
    endtask

    // Monitor: per-cycle status, empty-output values and head/pop ordering.
    initial begin
        cyc_t c;
        forever begin
            @(negedge clk);
            #2;
            while (cycq.size() > 0) begin
                c = cycq.pop_front();
                chk("if_ready", 32'(bus.if_ready), 32'(c.r));
                chk("id_valid", 32'(bus.id_valid), 32'(c.v));
`ifdef IF_ID_BUFFER_PERF_EN
                chk("stall_cnt", 32'(stall_cnt), 32'(c.sc));
                chk("flush_cnt", 32'(flush_cnt), 32'(c.fc));
`endif
                if (!c.v) begin
                    chk("empty_instr", 32'(bus.id_instr), 32'h0800);
                    chk("empty_pc", 32'(bus.id_pc_plus2), 32'd0);
                end else if (!c.fl) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL scoreboard: got entry %h with nothing expected", bus.id_instr);
                    end else begin
                        chk("head_instr", 32'(bus.id_instr), 32'(expq[0].instr));
                        chk("head_pc", 32'(bus.id_pc_plus2), 32'(expq[0].pc_plus2));
                        if (!c.st) void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic        pv;
        logic [15:0] pi, pp;
        int          n;

        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc_plus2 = '0;
        bus.id_stall = 1'b0; bus.flush = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset, then a single push/pop.
        idle(3);
        drive(1'b1, 16'h4000, 16'h0002, 1'b0, 1'b0, a);
        idle(2);

        // Stall with three offers: A, B accepted, C held until room.
        drive(1'b1, 16'hA0A0, 16'h0010, 1'b1, 1'b0, a);
        drive(1'b1, 16'hB0B0, 16'h0012, 1'b1, 1'b0, a);
        drive(1'b1, 16'hC0C0, 16'h0014, 1'b1, 1'b0, a);
        chk("c_refused_full", 32'(a), 32'd0);
        n = 0;
        do begin
            drive(1'b1, 16'hC0C0, 16'h0014, 1'b0, 1'b0, a);
            n++;
        end while (!a && n < 8);
        chk("c_accept_delay", 32'(n), 32'd2);
        idle(3);

        // Flush with two held and one offered.
        drive(1'b1, 16'hD0D0, 16'h0020, 1'b1, 1'b0, a);
        drive(1'b1, 16'hE0E0, 16'h0022, 1'b1, 1'b0, a);
        drive(1'b1, 16'hF0F0, 16'h0024, 1'b0, 1'b1, a);
        idle(2);

        // Asynchronous reset while two entries are held.
        drive(1'b1, 16'h1111, 16'h0030, 1'b1, 1'b0, a);
        drive(1'b1, 16'h2222, 16'h0032, 1'b1, 1'b0, a);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, a);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        occ = 0; expq.delete(); stall_mdl = 0; flush_mdl = 0;
        @(negedge clk);
        bus.if_valid = 1'b0; bus.id_stall = 1'b0; bus.flush = 1'b0;
        rst = 1'b1;
        idle(2);

`ifdef IF_ID_BUFFER_PERF_EN
        // Long stall on a held entry drives stall_cnt into saturation.
        drive(1'b1, 16'h5555, 16'h0040, 1'b1, 1'b0, a);
        for (int i = 0; i < 65540; i++) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk("stall_sat_model", 32'(stall_mdl), 32'd65535);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, a);
        idle(2);
`endif

        // Random traffic; fetch holds an unaccepted offer unless flushed.
        pv = 1'b0; pi = '0; pp = '0;
        for (int i = 0; i < 3000; i++) begin
            logic st, fl;
            if (!pv) begin
                pv = ($urandom_range(0, 2) != 0);
                pi = 16'($urandom);
                pp = 16'($urandom);
            end
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 15) == 0);
            drive(pv, pi, pp, st, fl, a);
            if (a || fl) pv = 1'b0;
        end

        n = 0;
        while (occ > 0 && n < 16) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, a);
            n++;
        end
        idle(1);
        @(negedge clk);
        #3;
        chk("drain_expq", 32'(expq.size()), 32'd0);
        chk("drain_occ", 32'(occ), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Pipeline boundary between the fetch stage and decode.
- Captures the fetched instruction and its PC+2 in a small in-order buffer.
- Decouples decode stalls from fetch with valid/ready backpressure.
- Discards wrong-path instructions on a control-flow redirect (flush).
- Presents a NOP with id_valid=0 to decode whenever it holds no valid entry.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, minimum 2.
- NOP_INSTR, 16'h0800, instruction word driven to decode when the buffer is empty.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- if_instr  input  16  instruction word from fetch.
- if_pc_plus2  input  16  PC+2 of if_instr, from fetch.
- if_valid  input  1  fetch offers an entry this cycle.
- if_ready  output  1  buffer can accept an entry; equals (count < DEPTH), combinational from registered count.
- id_stall  input  1  decode cannot consume this cycle.
- flush  input  1  redirect taken (jump, branch, siic, rti); discard all held and incoming entries.
- id_instr  output  16  head instruction, or NOP_INSTR when empty.
- id_pc_plus2  output  16  head PC+2, or 16'h0000 when empty.
- id_valid  output  1  head entry is valid (count != 0).

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, read and write pointers=0, storage contents don't-care.
  - Outputs: id_valid=0, id_instr=NOP_INSTR, id_pc_plus2=0, if_ready=1.
- Handshakes:
  - push = if_valid & if_ready & ~flush.
  - pop = id_valid & ~id_stall & ~flush.
- Push: write entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - count += push − pop.
  - Push and pop in the same cycle leaves count unchanged; legal whenever count is in 1..DEPTH−1.
- Latency: an entry pushed at edge N is visible at id_* after edge N; no same-cycle bypass from if_* to id_*.
- Full (count==DEPTH):
  - if_ready=0 and fetch must hold its PC.
  - No push even if a pop occurs that cycle; if_ready depends only on registered count.
- Empty (count==0): id_valid=0, id_instr=NOP_INSTR, id_pc_plus2=0, and id_stall is ignored.
- Flush:
  - Synchronous; the next edge sets count=0 and rd_ptr=wr_ptr=0.
  - The entry offered on the flush cycle is discarded; no pop is counted.
  - Flush has priority over push, pop and stall.
- Flush while empty: no effect beyond pointer reset.
- Pointers: log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits and never exceeds DEPTH.
- Reset mid-operation: all entries lost immediately; outputs take reset values asynchronously.
- Outputs are functions of registered state only; no if_* → id_* combinational path.

Optional Feature:
- Macro: IF_ID_BUFFER_PERF_EN.
- When defined, adds two 16-bit outputs:
  - stall_cnt: increments every cycle with id_valid & id_stall.
  - flush_cnt: increments on every flush cycle that discards at least one held or incoming valid entry.
- Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (pipeline defs):
  - NOP_INSTR constant (16'h0800).
  - Instruction and address width constant (16).
  - Default IF/ID depth.
  - A struct/typedef bundling {instr, pc_plus2} as one 32-bit entry.
- One sub-module, if_id_storage: DEPTH×32-bit register array with write-enable/write-pointer and combinational read at read-pointer.
- Pointer, count and flush control stay in if_id_buffer.

Test Plan:
- Reset then idle, rst=0→1 → id_valid=0, id_instr=16'h0800, id_pc_plus2=0, if_ready=1 on every cycle until first push.
- Push instr 16'h4000/pc 16'h0002 with id_stall=0 → next cycle id_valid=1, id_instr=16'h4000, id_pc_plus2=16'h0002; following cycle empty again if no further push.
- Hold id_stall=1 and push 3 entries (A, B, C):
  - A and B accepted; if_ready=0 after the second edge; C held by fetch.
  - Release stall → A, B, C emerge in order, one per cycle.
- Full buffer plus simultaneous pop and if_valid=1 → pop occurs, no push that cycle, count=1; push occurs the following cycle.
- Two entries held plus flush=1 with if_valid=1 → next cycle id_valid=0, id_instr=16'h0800, if_ready=1; the flushed-cycle input never appears.
- Assert rst=0 mid-stream while the buffer holds 2 entries → outputs go to reset values without waiting for a clock edge. With IF_ID_BUFFER_PERF_EN defined: stall_cnt and flush_cnt read 0 after reset and saturate at 16'hFFFF under long stall.
